mem_wb_skid: RTL and testbench
==============================

Name: mem_wb_skid

Overview:
Parametrised MEM/WB pipeline boundary, successor to the fixed single-lane MEM/WB register. Carries NUM_CH GPR write lanes plus HI/LO and CP0 write bundles. Adds valid/ready flow control through a 2-entry skid buffer, so a WB-side stall does not combinationally reach MEM. A synchronous flush drops in-flight writes on exceptions.

Parameters:
NUM_CH, 1, number of GPR write lanes (issue width), 1..4
DATA_W, 32, GPR/HI/LO/CP0 data width
RA_W, 5, GPR and CP0 register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous flush; drops both entries
mem_valid  in  1  MEM bundle valid
mem_ready  out  1  block can accept a bundle
mem_wd  in  NUM_CH*RA_W  GPR dest per lane; lane i at [i*RA_W +: RA_W]
mem_wreg  in  NUM_CH  GPR write enable per lane
mem_wdata  in  NUM_CH*DATA_W  GPR data per lane
mem_whilo  in  1  HI/LO write enable
mem_hi  in  DATA_W  HI data
mem_lo  in  DATA_W  LO data
mem_cp0_reg_we  in  1  CP0 write enable
mem_cp0_reg_write_addr  in  RA_W  CP0 address
mem_cp0_reg_data  in  DATA_W  CP0 data
wb_valid  out  1  WB bundle valid
wb_ready  in  1  WB consumes bundle
wb_wd  out  NUM_CH*RA_W  registered GPR dest
wb_wreg  out  NUM_CH  GPR enables, forced 0 when !wb_valid
wb_wdata  out  NUM_CH*DATA_W  GPR data
wb_whilo  out  1  forced 0 when !wb_valid
wb_hi / wb_lo  out  DATA_W  HI/LO data
wb_cp0_reg_we  out  1  forced 0 when !wb_valid
wb_cp0_reg_write_addr  out  RA_W  CP0 address
wb_cp0_reg_data  out  DATA_W  CP0 data

Behaviour:
- Storage: main entry drives the wb_* outputs; skid entry holds one overflow bundle. Each entry has its own valid bit.
- States: EMPTY (no entry valid), ONE (main valid), FULL (main and skid valid). wb_valid = main valid.
- mem_ready is a registered signal, high iff state != FULL. No combinational path exists from wb_ready to mem_ready.
- push = mem_valid & mem_ready; pop = wb_valid & wb_ready.
- EMPTY: push -> main, ONE.
- ONE:
  - push & pop -> main replaced, stay ONE.
  - push & !pop -> skid, FULL.
  - pop only -> EMPTY.
- FULL: pop -> skid moves to main, ONE. Push cannot occur (mem_ready low).
- Latency: 1 cycle from push into EMPTY or ONE-with-pop until the bundle appears on wb_*. Throughput is 1 bundle/cycle while wb_ready=1.
- Order is strictly FIFO. A bundle is never duplicated or dropped except by flush or reset.
- flush: next state EMPTY, mem_ready=1 next cycle. Flush has priority over a simultaneous push or pop; the pushed bundle is discarded.
- Reset (async, any state, including mid-transfer): all valids 0, state EMPTY, mem_ready 0 while rst is high and 1 on the first clock after release. Every wb_* data/address output is 0, and every enable is 0.
- Write enables are gated by valid. A registered enable of 1 is never visible when wb_valid=0.
- Data fields are loaded only on push or skid->main transfer. Otherwise they hold (no toggling when idle).

Optional Feature:
MEM_WB_SKID_PERF_EN:
- Defined: adds outputs perf_stall_cnt (32) and perf_flush_cnt (32).
  - perf_stall_cnt increments each cycle wb_valid & !wb_ready.
  - perf_flush_cnt increments each cycle flush is high while any entry is valid.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2);
  - bundle width constant BUNDLE_W = NUM_CH*(RA_W+1+DATA_W)+1+2*DATA_W+1+RA_W+DATA_W;
  - field offset localparams.
- One sub-module, skid_entry: a BUNDLE_W register with valid bit, load enable, async reset and clear. It is instantiated twice (main, skid).

Test Plan:
- Reset then stream: NUM_CH=2, push lane0 wd=5 wreg=1 wdata=0x1234, wb_ready=1 -> next cycle wb_valid=1, wb_wd[4:0]=5, wb_wdata[31:0]=0x1234; back-to-back bundles appear 1/cycle.
- Backpressure: wb_ready=0, push A then B -> state FULL, mem_ready=0 at cycle 3. Raise wb_ready -> A then B on consecutive cycles, mem_ready=1 after A pops.
- Flush in FULL with simultaneous push attempt: flush=1 -> next cycle wb_valid=0, wb_wreg=0, wb_whilo=0, wb_cp0_reg_we=0, mem_ready=1, no later emission of A, B or the pushed bundle.
- Async reset mid-stall: assert rst between clock edges with FULL -> wb_* immediately 0, wb_valid=0. After release, the first push (cp0_we=1, addr=12, data=0x0000FF01) emerges unchanged.
- Valid gating: push bundle with whilo=1 hi=0xDEAD, pop it, no further push -> wb_whilo=0 while wb_hi holds 0xDEAD.
- MEM_WB_SKID_PERF_EN: 3 stall cycles then 1 flush with an entry valid -> perf_stall_cnt=3, perf_flush_cnt=1.

Source files
------------

// File: rtl/mem_wb_skid_pkg.sv
// ============================================================================
// mem_wb_skid_pkg : state encoding and bundle field layout for mem_wb_skid
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_wb_skid_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

  // Fields are packed LSB-first in this order.
  typedef enum int {
    F_WD, F_WREG, F_WDATA, F_WHILO, F_HI, F_LO,
    F_CP0_WE, F_CP0_ADDR, F_CP0_DATA, F_END
  } field_e;

  function automatic int bundle_w(int num_ch, int ra_w, int data_w);
    return num_ch*(ra_w+1+data_w) + 1 + 2*data_w + 1 + ra_w + data_w;
  endfunction

  function automatic int field_w(field_e f, int num_ch, int ra_w, int data_w);
    case (f)
      F_WD:       return num_ch*ra_w;
      F_WREG:     return num_ch;
      F_WDATA:    return num_ch*data_w;
      F_WHILO:    return 1;
      F_HI:       return data_w;
      F_LO:       return data_w;
      F_CP0_WE:   return 1;
      F_CP0_ADDR: return ra_w;
      F_CP0_DATA: return data_w;
      default:    return 0;
    endcase
  endfunction

  function automatic int field_off(field_e f, int num_ch, int ra_w, int data_w);
    int off;
    off = 0;
    for (int i = 0; i < int'(f); i++)
      off += field_w(field_e'(i), num_ch, ra_w, data_w);
    return off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_skid_if.sv
// ============================================================================
// mem_wb_skid_if : valid/ready write-back bundle (GPR lanes, HI/LO, CP0)
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_wb_skid_if #(
  parameter int NUM_CH = 1,
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
);
  logic                     valid;
  logic                     ready;
  logic [NUM_CH*RA_W-1:0]   wd;
  logic [NUM_CH-1:0]        wreg;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic                     whilo;
  logic [DATA_W-1:0]        hi;
  logic [DATA_W-1:0]        lo;
  logic                     cp0_reg_we;
  logic [RA_W-1:0]          cp0_reg_write_addr;
  logic [DATA_W-1:0]        cp0_reg_data;

  modport master (
    output valid, wd, wreg, wdata, whilo, hi, lo,
           cp0_reg_we, cp0_reg_write_addr, cp0_reg_data,
    input  ready
  );

  modport slave (
    input  valid, wd, wreg, wdata, whilo, hi, lo,
           cp0_reg_we, cp0_reg_write_addr, cp0_reg_data,
    output ready
  );
endinterface

`default_nettype wire

// File: rtl/mem_wb_skid_skid_entry.sv
// ============================================================================
// skid_entry : one bundle register with valid bit; clear beats load
// Rev 1.0
// ============================================================================
`default_nettype none

module skid_entry #(
  parameter int W = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         clr,
  input  wire logic         load,
  input  wire logic [W-1:0] d,
  output logic              valid,
  output logic [W-1:0]      q
);

  // Clear only drops the valid bit; data holds to avoid idle toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_skid.sv
// ============================================================================
// mem_wb_skid : MEM/WB boundary with 2-entry skid buffer and flush.
// Optional perf counters: MEM_WB_SKID_PERF_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  wire logic     clk,
  input  wire logic     rst,
  input  wire logic     flush,
  mem_wb_skid_if.slave  mem,
  mem_wb_skid_if.master wb
`ifdef MEM_WB_SKID_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_flush_cnt
`endif
);

  localparam int BUNDLE_W = bundle_w(NUM_CH, RA_W, DATA_W);
  localparam int O_WREG   = field_off(F_WREG,     NUM_CH, RA_W, DATA_W);
  localparam int O_WDATA  = field_off(F_WDATA,    NUM_CH, RA_W, DATA_W);
  localparam int O_WHILO  = field_off(F_WHILO,    NUM_CH, RA_W, DATA_W);
  localparam int O_HI     = field_off(F_HI,       NUM_CH, RA_W, DATA_W);
  localparam int O_LO     = field_off(F_LO,       NUM_CH, RA_W, DATA_W);
  localparam int O_CP0_WE = field_off(F_CP0_WE,   NUM_CH, RA_W, DATA_W);
  localparam int O_CP0_A  = field_off(F_CP0_ADDR, NUM_CH, RA_W, DATA_W);
  localparam int O_CP0_D  = field_off(F_CP0_DATA, NUM_CH, RA_W, DATA_W);

  state_t              state, state_nxt;
  logic                ready_q;
  logic                push, pop;
  logic                main_load, main_clr, skid_load, skid_clr;
  logic                main_vld, skid_vld;
  logic [BUNDLE_W-1:0] in_bundle, main_d, main_q, skid_q;

  assign in_bundle = {mem.cp0_reg_data, mem.cp0_reg_write_addr, mem.cp0_reg_we,
                      mem.lo, mem.hi, mem.whilo, mem.wdata, mem.wreg, mem.wd};

  assign push = mem.valid & ready_q;
  assign pop  = main_vld & wb.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != ST_FULL);
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (push) state_nxt = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_nxt = ST_FULL;
          else if (!push && pop) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = push;
        ST_ONE: begin
          main_load = push & pop;
          skid_load = push & ~pop;
          main_clr  = pop & ~push;
        end
        ST_FULL: begin
          main_load = pop;
          skid_clr  = pop;
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // A valid skid entry is always older than anything arriving from MEM.
  assign main_d = skid_vld ? skid_q : in_bundle;

  skid_entry #(.W(BUNDLE_W)) u_main (
    .clk(clk), .rst(rst), .clr(main_clr), .load(main_load),
    .d(main_d), .valid(main_vld), .q(main_q)
  );

  skid_entry #(.W(BUNDLE_W)) u_skid (
    .clk(clk), .rst(rst), .clr(skid_clr), .load(skid_load),
    .d(in_bundle), .valid(skid_vld), .q(skid_q)
  );

  assign mem.ready             = ready_q;
  assign wb.valid              = main_vld;
  assign wb.wd                 = main_q[0 +: NUM_CH*RA_W];
  assign wb.wreg               = main_q[O_WREG +: NUM_CH] & {NUM_CH{main_vld}};
  assign wb.wdata              = main_q[O_WDATA +: NUM_CH*DATA_W];
  assign wb.whilo              = main_q[O_WHILO] & main_vld;
  assign wb.hi                 = main_q[O_HI +: DATA_W];
  assign wb.lo                 = main_q[O_LO +: DATA_W];
  assign wb.cp0_reg_we         = main_q[O_CP0_WE] & main_vld;
  assign wb.cp0_reg_write_addr = main_q[O_CP0_A +: RA_W];
  assign wb.cp0_reg_data       = main_q[O_CP0_D +: DATA_W];

`ifdef MEM_WB_SKID_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (main_vld && !wb.ready)         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush && (main_vld || skid_vld)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_skid.sv
// ============================================================================
// tb_mem_wb_skid : scoreboard bench for mem_wb_skid (NUM_CH=2)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_wb_skid;
  import mem_wb_skid_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int BW     = bundle_w(NUM_CH, RA_W, DATA_W);
  localparam int WD_W   = NUM_CH*RA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  mem_wb_skid_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RA_W(RA_W)) mem_if ();
  mem_wb_skid_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RA_W(RA_W)) wb_if ();

`ifdef MEM_WB_SKID_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  mem_wb_skid #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mem(mem_if), .wb(wb_if)
`ifdef MEM_WB_SKID_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int stall_m = 0;
  int flush_m = 0;
  logic [255:0] sbq[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_vec();
    logic [255:0] v;
    v = '0;
    v[BW-1:0] = {mem_if.cp0_reg_data, mem_if.cp0_reg_write_addr, mem_if.cp0_reg_we,
                 mem_if.lo, mem_if.hi, mem_if.whilo, mem_if.wdata, mem_if.wreg, mem_if.wd};
    return v;
  endfunction

  function automatic logic [255:0] wb_vec();
    logic [255:0] v;
    v = '0;
    v[BW-1:0] = {wb_if.cp0_reg_data, wb_if.cp0_reg_write_addr, wb_if.cp0_reg_we,
                 wb_if.lo, wb_if.hi, wb_if.whilo, wb_if.wdata, wb_if.wreg, wb_if.wd};
    return v;
  endfunction

  task automatic rand_bundle();
    mem_if.wd                 = WD_W'($urandom);
    mem_if.wreg               = NUM_CH'($urandom);
    mem_if.wdata              = {$urandom, $urandom};
    mem_if.whilo              = 1'($urandom);
    mem_if.hi                 = $urandom;
    mem_if.lo                 = $urandom;
    mem_if.cp0_reg_we         = 1'($urandom);
    mem_if.cp0_reg_write_addr = RA_W'($urandom);
    mem_if.cp0_reg_data       = $urandom;
  endtask

  // Evaluated mid low phase: exactly the handshake the next rising edge takes.
  task automatic eval_cycle();
    logic push, pop;
    if (rst) begin
      sbq.delete();
      stall_m = 0;
      flush_m = 0;
      return;
    end
    push = mem_if.valid & mem_if.ready;
    pop  = wb_if.valid & wb_if.ready;
    if (wb_if.valid && !wb_if.ready) stall_m++;
    if (flush) begin
      if (sbq.size() != 0) flush_m++;
      sbq.delete();
      return;
    end
    if (pop) begin
      check_eq("sb_nonempty", 256'(sbq.size() != 0), 256'(1));
      if (sbq.size() != 0) check_eq("wb_bundle", wb_vec(), sbq.pop_front());
    end
    if (push) sbq.push_back(mem_vec());
  endtask

  task automatic tick();
    #1;
    eval_cycle();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    mem_if.valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill_two();
    wb_if.ready = 1'b0;
    rand_bundle(); mem_if.valid = 1'b1; tick();
    rand_bundle(); tick();
    mem_if.valid = 1'b0;
  endtask

  initial begin
    mem_if.valid = 1'b0;
    wb_if.ready  = 1'b0;
    rand_bundle();
    @(negedge clk);

    // reset state
    check_eq("rst_ready", 256'(mem_if.ready), 256'(0));
    check_eq("rst_valid", 256'(wb_if.valid), 256'(0));
    check_eq("rst_outputs", wb_vec(), 256'(0));
    tick();
    rst = 1'b0;
    tick();
    check_eq("ready_after_rst", 256'(mem_if.ready), 256'(1));

    // first push and back-to-back stream
    wb_if.ready = 1'b1;
    rand_bundle();
    mem_if.wd[4:0] = 5'd5;
    mem_if.wreg = 2'b01;
    mem_if.wdata[31:0] = 32'h1234;
    mem_if.valid = 1'b1;
    tick();
    check_eq("first_valid", 256'(wb_if.valid), 256'(1));
    check_eq("first_wd", 256'(wb_if.wd[4:0]), 256'(5));
    check_eq("first_wdata", 256'(wb_if.wdata[31:0]), 256'(32'h1234));
    for (int i = 0; i < 6; i++) begin
      rand_bundle();
      tick();
      check_eq("stream_valid", 256'(wb_if.valid), 256'(1));
    end
    idle(1);
    check_eq("stream_drained", 256'(wb_if.valid), 256'(0));

    // backpressure into FULL, then drain
    fill_two();
    check_eq("full_ready_low", 256'(mem_if.ready), 256'(0));
    check_eq("full_valid", 256'(wb_if.valid), 256'(1));
    wb_if.ready = 1'b1;
    tick();
    check_eq("ready_after_pop", 256'(mem_if.ready), 256'(1));
    check_eq("b_valid", 256'(wb_if.valid), 256'(1));
    tick();
    check_eq("bp_drained", 256'(wb_if.valid), 256'(0));

    // flush in FULL with a push attempt
    fill_two();
    rand_bundle(); mem_if.valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; mem_if.valid = 1'b0;
    check_eq("flush_valid", 256'(wb_if.valid), 256'(0));
    check_eq("flush_wreg", 256'(wb_if.wreg), 256'(0));
    check_eq("flush_whilo", 256'(wb_if.whilo), 256'(0));
    check_eq("flush_cp0_we", 256'(wb_if.cp0_reg_we), 256'(0));
    check_eq("flush_ready", 256'(mem_if.ready), 256'(1));
    wb_if.ready = 1'b1;
    idle(3);
    check_eq("flush_no_emit", 256'(wb_if.valid), 256'(0));

    // flush in ONE beating a simultaneous push and pop
    rand_bundle(); mem_if.valid = 1'b1; tick();
    rand_bundle(); flush = 1'b1; tick();
    flush = 1'b0; mem_if.valid = 1'b0;
    check_eq("flush_one_valid", 256'(wb_if.valid), 256'(0));
    idle(2);
    check_eq("flush_one_no_emit", 256'(wb_if.valid), 256'(0));

    // asynchronous reset while FULL
    fill_two();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 256'(wb_if.valid), 256'(0));
    check_eq("arst_outputs", wb_vec(), 256'(0));
    check_eq("arst_ready", 256'(mem_if.ready), 256'(0));
    tick();
    rst = 1'b0;
    tick();
    check_eq("arst_ready_back", 256'(mem_if.ready), 256'(1));
    wb_if.ready = 1'b1;
    rand_bundle();
    mem_if.whilo = 1'b0; mem_if.wreg = '0;
    mem_if.cp0_reg_we = 1'b1; mem_if.cp0_reg_write_addr = 5'd12;
    mem_if.cp0_reg_data = 32'h0000FF01;
    mem_if.valid = 1'b1;
    tick();
    mem_if.valid = 1'b0;
    check_eq("cp0_we", 256'(wb_if.cp0_reg_we), 256'(1));
    check_eq("cp0_addr", 256'(wb_if.cp0_reg_write_addr), 256'(12));
    check_eq("cp0_data", 256'(wb_if.cp0_reg_data), 256'(32'h0000FF01));
    idle(1);

    // enable gating with held data
    rand_bundle(); mem_if.whilo = 1'b1; mem_if.hi = 32'hDEAD; mem_if.valid = 1'b1;
    tick();
    idle(1);
    check_eq("gate_whilo", 256'(wb_if.whilo), 256'(0));
    check_eq("hold_hi", 256'(wb_if.hi), 256'(32'hDEAD));
    idle(2);
    check_eq("hold_hi_idle", 256'(wb_if.hi), 256'(32'hDEAD));

    // stalls then a flush with an entry valid
    wb_if.ready = 1'b0;
    rand_bundle(); mem_if.valid = 1'b1; tick();
    idle(3);
`ifdef MEM_WB_SKID_PERF_EN
    check_eq("perf_stall", 256'(perf_stall_cnt), 256'(stall_m));
    check_eq("perf_stall_abs", 256'(perf_stall_cnt), 256'(3));
`endif
    flush = 1'b1; tick(); flush = 1'b0;
`ifdef MEM_WB_SKID_PERF_EN
    check_eq("perf_flush", 256'(perf_flush_cnt), 256'(flush_m));
    check_eq("perf_flush_abs", 256'(perf_flush_cnt), 256'(1));
`endif

    wb_if.ready = 1'b1;
    idle(3);
    check_eq("sb_drained", 256'(sbq.size()), 256'(0));
    check_eq("end_valid", 256'(wb_if.valid), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
